// File: rtl/audio_input_capture.sv
// audio_input_capture: pops Audio_Controller ADC frames, mixes to mono, decimates onto a valid/ready stream, tracks windowed peak.
//   clk, resetn                 : clock, synchronous active-low reset
//   audio_in_available          : controller input FIFO not empty
//   left/right_channel_audio_in : frames, signed sample in [31:16]
//   read_audio_in               : one-cycle pop strobe
//   sample, sample_valid, sample_ready : mono output stream
//   peak, peak_strobe           : peak magnitude of last window, update pulse
module audio_input_capture #(
  parameter int DECIM  = 1,
  parameter int WINDOW = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [15:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [15:0] peak,
  output logic        peak_strobe
);
  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;
  localparam logic [7:0]  DEC_MAX = 8'(DECIM - 1);
  localparam logic [15:0] WIN_MAX = 16'(WINDOW - 1);
  state_t state_q, state_d;
  logic [15:0] l_q, l_d, r_q, r_d, sample_q, sample_d, peak_q, peak_d;
  logic [15:0] run_max_q, run_max_d, win_cnt_q, win_cnt_d;
  logic [7:0] dec_cnt_q, dec_cnt_d;
  logic rd_q, rd_d, valid_q, valid_d, pstb_q, pstb_d;
  logic [16:0] sum;
  logic [15:0] mono, mag, new_max;
  logic pop_ok;
  logic unused_lo;
  assign unused_lo = ^{left_channel_audio_in[15:0], right_channel_audio_in[15:0], sum[0]};
  always_comb begin
    sum = {l_q[15], l_q} + {r_q[15], r_q};
    mono = sum[16:1];
    mag = !mono[15] ? mono : mono == 16'h8000 ? 16'h7fff : ~mono + 16'd1;
    new_max = mag > run_max_q ? mag : run_max_q;
    // a decimation-hit pop needs an empty slot so load and transfer never collide
    pop_ok = dec_cnt_q != DEC_MAX || !valid_q;
    state_d = state_q;
    l_d = l_q;
    r_d = r_q;
    rd_d = 1'b0;
    sample_d = sample_q;
    valid_d = valid_q && !sample_ready;
    peak_d = peak_q;
    pstb_d = 1'b0;
    dec_cnt_d = dec_cnt_q;
    win_cnt_d = win_cnt_q;
    run_max_d = run_max_q;
    case (state_q)
      IDLE: if (audio_in_available && pop_ok) begin
        l_d = left_channel_audio_in[31:16];
        r_d = right_channel_audio_in[31:16];
        rd_d = 1'b1;
        state_d = POP;
      end
      POP: begin
        state_d = SETTLE;
        if (dec_cnt_q == DEC_MAX) begin
          sample_d = mono;
          valid_d = 1'b1;
          dec_cnt_d = 8'd0;
        end else dec_cnt_d = dec_cnt_q + 8'd1;
        if (win_cnt_q == WIN_MAX) begin
          peak_d = new_max;
          pstb_d = 1'b1;
          run_max_d = 16'd0;
          win_cnt_d = 16'd0;
        end else begin
          run_max_d = new_max;
          win_cnt_d = win_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      l_q <= 16'd0;
      r_q <= 16'd0;
      rd_q <= 1'b0;
      sample_q <= 16'd0;
      valid_q <= 1'b0;
      peak_q <= 16'd0;
      pstb_q <= 1'b0;
      dec_cnt_q <= 8'd0;
      win_cnt_q <= 16'd0;
      run_max_q <= 16'd0;
    end else begin
      state_q <= state_d;
      l_q <= l_d;
      r_q <= r_d;
      rd_q <= rd_d;
      sample_q <= sample_d;
      valid_q <= valid_d;
      peak_q <= peak_d;
      pstb_q <= pstb_d;
      dec_cnt_q <= dec_cnt_d;
      win_cnt_q <= win_cnt_d;
      run_max_q <= run_max_d;
    end
  end
  assign read_audio_in = rd_q;
  assign sample = sample_q;
  assign sample_valid = valid_q;
  assign peak = peak_q;
  assign peak_strobe = pstb_q;
endmodule
